// File: rtl/mod_mem_pkg.sv
// Shared types and constants for the memory-stage sequencer (mod_mem_ctrl).
// XLEN and FUNCT3_WIDTH fall back to RV32 values when the core does not define them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

package mod_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  localparam logic [`FUNCT3_WIDTH-1:0] LB  = 3'b000;
  localparam logic [`FUNCT3_WIDTH-1:0] LH  = 3'b001;
  localparam logic [`FUNCT3_WIDTH-1:0] LW  = 3'b010;
  localparam logic [`FUNCT3_WIDTH-1:0] LBU = 3'b100;
  localparam logic [`FUNCT3_WIDTH-1:0] LHU = 3'b101;

  localparam int BE_W = `XLEN / 8;

endpackage

// File: rtl/mod_lsu_align.sv
// Combinational lane logic: byte enables and write-data replication for requests,
// load-lane selection and sign/zero extension for responses.
module mod_lsu_align
  import mod_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [`FUNCT3_WIDTH-1:0] req_funct3_i,
  input  logic [1:0]               req_off_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [BE_W-1:0]          be_o,
  output logic [DATA_W-1:0]        wdata_o,
  input  logic [`FUNCT3_WIDTH-1:0] rsp_funct3_i,
  input  logic [1:0]               rsp_off_i,
  input  logic [DATA_W-1:0]        rdata_i,
  output logic [DATA_W-1:0]        load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    case (req_funct3_i)
      LB, LBU: begin
        be_o    = BE_W'(1) << req_off_i;
        wdata_o = {BE_W{wdata_i[7:0]}};
      end
      LH, LHU: begin
        be_o    = BE_W'(3) << {req_off_i[1], 1'b0};
        wdata_o = {(BE_W / 2){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Half loads ignore offset bit 0, so they always come from lane 0 or lane 2.
  always_comb begin
    byte_sel    = rdata_i[{rsp_off_i, 3'b000} +: 8];
    half_sel    = rdata_i[{rsp_off_i[1], 4'b0000} +: 16];
    sign_en     = ~rsp_funct3_i[2];
    load_data_o = rdata_i;
    case (rsp_funct3_i)
      LB, LBU: load_data_o = {{(DATA_W - 8){byte_sel[7] & sign_en}}, byte_sel};
      LH, LHU: load_data_o = {{(DATA_W - 16){half_sel[15] & sign_en}}, half_sel};
      LW:      load_data_o = rdata_i;
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mod_mem_ctrl.sv
// Memory-stage sequencer: turns EX/MEM load/store control into one req/gnt/rvalid transaction.
// Optional MEM_MISALIGN_CHK_EN rejects misaligned half/word accesses with err_o instead of a request.
module mod_mem_ctrl
  import mod_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0,
  parameter int TMO_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     hold_i,
  input  logic                     mem_read_en_i,
  input  logic                     mem_write_en_i,
  input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
  input  logic [DATA_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [DATA_W-1:0]        dmem_addr_o,
  output logic [DATA_W/8-1:0]      dmem_be_o,
  output logic [DATA_W-1:0]        dmem_wdata_o,
  input  logic                     dmem_gnt_i,
  input  logic                     dmem_rvalid_i,
  input  logic [DATA_W-1:0]        dmem_rdata_i,
  output logic [DATA_W-1:0]        load_data_o,
  output logic                     stall_o,
  output logic                     err_o
);

  state_e                   state_q, state_d;
  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic                     err_q, err_d;
  logic [DATA_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0]        load_q, load_d;
  logic [BE_W-1:0]          be_q, be_d;
  logic [`FUNCT3_WIDTH-1:0] f3_q, f3_d;
  logic [1:0]               off_q, off_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;

  logic                     access_v;
  logic                     timeout;
  logic [BE_W-1:0]          be_w;
  logic [DATA_W-1:0]        wdata_w;
  logic [DATA_W-1:0]        load_w;

  mod_lsu_align #(.DATA_W(DATA_W)) u_align (
    .req_funct3_i (funct3_i),
    .req_off_i    (addr_i[1:0]),
    .wdata_i      (wdata_i),
    .be_o         (be_w),
    .wdata_o      (wdata_w),
    .rsp_funct3_i (f3_q),
    .rsp_off_i    (off_q),
    .rdata_i      (dmem_rdata_i),
    .load_data_o  (load_w)
  );

  assign access_v = mem_read_en_i | mem_write_en_i;
  assign timeout  = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_CHK_EN
  logic misalign;
  always_comb begin
    case (funct3_i)
      LB, LBU: misalign = 1'b0;
      LH, LHU: misalign = addr_i[0];
      default: misalign = |addr_i[1:0];
    endcase
  end
`endif

  // Stall is gated by reset so a held-over access cannot stall the pipe while in reset.
  assign stall_o = rst_ni & (((state_q == IDLE) & access_v) | (state_q == REQ) | (state_q == RESP));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (access_v) begin
          we_d    = mem_write_en_i;
          addr_d  = {addr_i[DATA_W-1:2], 2'b00};
          be_d    = be_w;
          wdata_d = wdata_w;
          f3_d    = funct3_i;
          off_d   = addr_i[1:0];
`ifdef MEM_MISALIGN_CHK_EN
          if (misalign) begin
            err_d   = 1'b1;
            load_d  = '0;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            state_d = REQ;
          end
`else
          req_d   = 1'b1;
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          load_d  = '0;
          state_d = DONE;
        end else if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : RESP;
        end
      end
      RESP: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout) begin
          err_d   = 1'b1;
          load_d  = '0;
          state_d = DONE;
        end else if (dmem_rvalid_i) begin
          load_d  = load_w;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = load_q;
  assign err_o        = err_q;

endmodule
